// File: rtl/fabric_config_loader.sv
// Configuration-chain loader for one CLB grid: serializes host beats into the
// per-column shift/cen chains and closes each load with a one-cycle set pulse.
module fabric_config_loader #(
    parameter int MX        = 3,
    parameter int CHAIN_LEN = 64,
    parameter int BPC       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [MX-1:0]     col_mask,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MX*BPC-1:0] in_data,
    output logic [MX-1:0]     cfg_shift,
    output logic [MX-1:0]     cfg_cen,
    output logic [MX-1:0]     cfg_set,
    output logic              busy,
    output logic              done
);

    localparam int              BW       = (BPC > 1) ? $clog2(BPC) : 1;
    localparam int              CW       = $clog2(CHAIN_LEN + 1);
    localparam logic [BW-1:0]   LAST_IDX = BW'(BPC - 1);
    localparam logic [CW-1:0]   FULL_CNT = CW'(CHAIN_LEN);

    typedef enum logic [1:0] {IDLE, LOAD, COMMIT, DONE} state_t;

    state_t              state, state_n;
    logic [MX-1:0]       mask, mask_n;
    logic [MX*BPC-1:0]   sbuf, sbuf_n;
    logic [BW-1:0]       beat_idx, beat_idx_n;
    logic                pending, pending_n;
    logic [CW-1:0]       bit_cnt, bit_cnt_n;
    logic [MX-1:0]       shift_n, cen_n;
    logic                accept;
    logic [BW-1:0]       idx;
    logic [MX*BPC-1:0]   src;

    // bit_cnt counts bits already driven onto cfg_shift (the one on the wire
    // included); pending means the buffer still holds bits after that one.
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_n    = state;
        mask_n     = mask;
        sbuf_n     = sbuf;
        beat_idx_n = beat_idx;
        pending_n  = pending;
        bit_cnt_n  = bit_cnt;
        shift_n    = '0;
        cen_n      = '0;
        accept     = in_valid && in_ready;
        idx        = accept ? '0 : beat_idx;
        src        = accept ? in_data : sbuf;

        case (state)
            IDLE: begin
                if (start) begin
                    mask_n     = col_mask;
                    bit_cnt_n  = '0;
                    beat_idx_n = '0;
                    pending_n  = 1'b0;
                    state_n    = (col_mask == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (bit_cnt == FULL_CNT) begin
                    state_n = COMMIT;
                end else if (accept || pending) begin
                    // A fresh beat emits its bit 0 straight from in_data so the
                    // stream has no bubble across beat boundaries.
                    for (int x = 0; x < MX; x++) begin
                        shift_n[x] = src[x*BPC + int'(idx)] & mask[x];
                    end
                    cen_n      = mask;
                    sbuf_n     = src;
                    beat_idx_n = idx + 1'b1;
                    pending_n  = (idx != LAST_IDX);
                    bit_cnt_n  = bit_cnt + 1'b1;
                end
            end
            COMMIT:  state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // NOTE: state and registered outputs use non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mask      <= '0;
            sbuf      <= '0;
            beat_idx  <= '0;
            pending   <= 1'b0;
            bit_cnt   <= '0;
            cfg_shift <= '0;
            cfg_cen   <= '0;
            cfg_set   <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            mask      <= mask_n;
            sbuf      <= sbuf_n;
            beat_idx  <= beat_idx_n;
            pending   <= pending_n;
            bit_cnt   <= bit_cnt_n;
            cfg_shift <= shift_n;
            cfg_cen   <= cen_n;
            cfg_set   <= (state_n == COMMIT) ? mask_n : '0;
            in_ready  <= (state_n == LOAD) && !pending_n && (bit_cnt_n != FULL_CNT);
            busy      <= (state_n != IDLE);
            done      <= (state_n == DONE);
        end
    end

endmodule
